shader_affine_pipe: RTL and testbench
=====================================

// Module: shader_affine_pipe
// PURPOSE
//  Parametrised, fully pipelined affine texel-coordinate generator for the shader path.
//  Maps screen pixel (px,py) to texel (tu,tv) = M*(p - q) + o, where M is a signed fixed-point 2x2 matrix.
//  Accepts one pixel per clock with valid/ready flow control; sits between the pixel interval counters and the texture fetch.
//  Config is snapshotted per pixel, so matrix updates never corrupt in-flight pixels.
// PARAMETERS
//  W     12  coordinate width (px,py,qx,qy,ox,oy,tu,tv), unsigned
//  MW    12  matrix coefficient width, two's complement
//  FRAC  8   fraction bits of coefficients (1.0 = 1<<FRAC)
//  SAT   1   1: clamp result to [0, 2^W-1]; 0: wrap modulo 2^W
// PORTS
//  aclk       in   1      clock
//  aresetn    in   1      async active-low reset
//  cfg_wen    in   1      load all cfg_* registers this cycle
//  cfg_qx     in   W      square position X
//  cfg_qy     in   W      square position Y
//  cfg_ox     in   W      texel origin X offset
//  cfg_oy     in   W      texel origin Y offset
//  cfg_m      in   4*MW   {d,c,b,a}; a=[MW-1:0]; u=a*dx+b*dy, v=c*dx+d*dy
//  s_valid    in   1      pixel input valid
//  s_ready    out  1      pixel input accepted when s_valid&s_ready
//  px         in   W      pixel X
//  py         in   W      pixel Y
//  m_valid    out  1      result valid
//  m_ready    in   1      downstream accepts result
//  tu         out  W      texel U
//  tv         out  W      texel V
//  oob        out  1      unclamped/unwrapped result outside [0,2^W-1] on either axis
// BEHAVIOUR
//  Reset (async, immediate): m_valid=0, tu=tv=0, oob=0, all stage valids=0.
//   Config regs reset to a=d=1<<FRAC, b=c=0, q=o=0 (identity transform).
//  Config: registered on cfg_wen at the clock edge. A pixel accepted in the same cycle uses the old config.
//   Pixels accepted from the next cycle on use the new config.
//   Stage 1 copies M,o alongside each pixel; later stages never read the live config regs.
//  Pipeline: 3 stages, global advance = ~m_valid | m_ready.
//   s_ready = advance (combinational from m_valid/m_ready only; no dependence on s_valid).
//   S1: dx = {0,px}-{0,qx}, dy = {0,py}-{0,qy}, signed W+1 bits; capture M,o.
//   S2: four products, signed W+MW+1 bits each.
//   S3: sum signed W+MW+2 bits; arithmetic >>> FRAC (floor toward -inf).
//       Add zero-extended o; clamp or wrap; register tu, tv, oob.
//  Latency: 3 cycles from acceptance to m_valid when unstalled. Throughput: 1 pixel/clock.
//  Stall: while m_valid & ~m_ready, all stages hold; tu/tv/oob are stable; no pixel dropped or duplicated.
//   Order is strictly preserved. Bubbles propagate as cleared stage valids.
//  SAT=1: negative -> 0, >2^W-1 -> 2^W-1. SAT=0: low W bits. oob is identical in both modes.
//  cfg_wen has no effect on stage valids and never stalls the pipe; it may be asserted every cycle.
//  Reset mid-operation: all in-flight pixels are discarded and config returns to identity.
// TESTING
//  Identity: q=(100,50), o=0, p=(130,70) -> tu=30, tv=20, oob=0, m_valid exactly 3 cycles after accept.
//  Rotate 90 (a=0,b=-256,c=256,d=0), q=0, o=(100,100), p=(10,4):
//   -> tu=96, tv=110. With o=0 -> tu=0 (SAT=1), oob=1.
//  Scale 0.5 (a=d=128): o=(8,8), p-q=(7,-7) -> tu=11 (3+8), tv=4 (-4+8 floor).
//   SAT=0, o=0, dy=-7 -> tv=0xFFC.
//  Backpressure: stream 16 pixels, m_ready low cycles 5-9 -> s_ready low within those cycles.
//   All 16 results out in order, values held while stalled.
//  Config mid-stream: cfg_wen with a=512 coincident with accept of pixel k.
//   -> pixel k uses the old matrix, k+1 the new; in-flight results unaffected.
//  Reset mid-stream: aresetn low with 3 pixels in flight -> m_valid=0 same cycle.
//   After release, identity config with no stale outputs.

Source files
------------

// File: rtl/shader_affine_pipe.sv
// Affine texel-coordinate generator: (tu,tv) = M*(p - q) + o.
// Three-stage valid/ready pipeline with per-pixel config snapshot.
module shader_affine_pipe #(
    parameter int W    = 12,
    parameter int MW   = 12,
    parameter int FRAC = 8,
    parameter int SAT  = 1
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            cfg_wen,
    input  logic [W-1:0]    cfg_qx,
    input  logic [W-1:0]    cfg_qy,
    input  logic [W-1:0]    cfg_ox,
    input  logic [W-1:0]    cfg_oy,
    input  logic [4*MW-1:0] cfg_m,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [W-1:0]    px,
    input  logic [W-1:0]    py,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [W-1:0]    tu,
    output logic [W-1:0]    tv,
    output logic            oob
);

    localparam int DW = W + 1;
    localparam int PW = W + MW + 1;
    localparam int SW = W + MW + 2;
    localparam int RW = W + MW + 3;
    localparam logic [MW-1:0] ONE = MW'(1 << FRAC);
    localparam logic [4*MW-1:0] M_ID = {ONE, {MW{1'b0}}, {MW{1'b0}}, ONE};

    logic [W-1:0]    cfg_qx_q, cfg_qx_d, cfg_qy_q, cfg_qy_d;
    logic [W-1:0]    cfg_ox_q, cfg_ox_d, cfg_oy_q, cfg_oy_d;
    logic [4*MW-1:0] cfg_m_q, cfg_m_d;

    logic                 s1_valid_q, s1_valid_d;
    logic signed [DW-1:0] s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;
    logic [4*MW-1:0]      s1_m_q, s1_m_d;
    logic [W-1:0]         s1_ox_q, s1_ox_d, s1_oy_q, s1_oy_d;

    logic                 s2_valid_q, s2_valid_d;
    logic signed [PW-1:0] s2_pa_q, s2_pa_d, s2_pb_q, s2_pb_d;
    logic signed [PW-1:0] s2_pc_q, s2_pc_d, s2_pd_q, s2_pd_d;
    logic [W-1:0]         s2_ox_q, s2_ox_d, s2_oy_q, s2_oy_d;

    logic         m_valid_q, m_valid_d;
    logic [W-1:0] tu_q, tu_d, tv_q, tv_d;
    logic         oob_q, oob_d;

    logic                 advance;
    logic signed [MW-1:0] ma, mb, mc, md;
    logic signed [SW-1:0] sum_u, sum_v, sh_u, sh_v;
    logic signed [RW-1:0] res_u, res_v;

    function automatic logic out_of_range(input logic signed [RW-1:0] r);
        return r[RW-1] | (|r[RW-2:W]);
    endfunction

    function automatic logic [W-1:0] fit(input logic signed [RW-1:0] r);
        logic [W-1:0] f;
        f = r[W-1:0];
        if (SAT != 0) begin
            if (r[RW-1])
                f = '0;
            else if (|r[RW-2:W])
                f = '1;
        end
        return f;
    endfunction

    assign advance = ~m_valid_q | m_ready;
    assign s_ready = advance;
    assign m_valid = m_valid_q;
    assign tu      = tu_q;
    assign tv      = tv_q;
    assign oob     = oob_q;

    assign ma = s1_m_q[MW-1:0];
    assign mb = s1_m_q[2*MW-1:MW];
    assign mc = s1_m_q[3*MW-1:2*MW];
    assign md = s1_m_q[4*MW-1:3*MW];

    always_comb begin
        cfg_qx_d = cfg_qx_q;
        cfg_qy_d = cfg_qy_q;
        cfg_ox_d = cfg_ox_q;
        cfg_oy_d = cfg_oy_q;
        cfg_m_d  = cfg_m_q;
        if (cfg_wen) begin
            cfg_qx_d = cfg_qx;
            cfg_qy_d = cfg_qy;
            cfg_ox_d = cfg_ox;
            cfg_oy_d = cfg_oy;
            cfg_m_d  = cfg_m;
        end
    end

    // Stage 1 reads the config registers before this edge's update lands.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_dx_d    = s1_dx_q;
        s1_dy_d    = s1_dy_q;
        s1_m_d     = s1_m_q;
        s1_ox_d    = s1_ox_q;
        s1_oy_d    = s1_oy_q;
        if (advance) begin
            s1_valid_d = s_valid;
            if (s_valid) begin
                s1_dx_d = $signed({1'b0, px}) - $signed({1'b0, cfg_qx_q});
                s1_dy_d = $signed({1'b0, py}) - $signed({1'b0, cfg_qy_q});
                s1_m_d  = cfg_m_q;
                s1_ox_d = cfg_ox_q;
                s1_oy_d = cfg_oy_q;
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_pa_d    = s2_pa_q;
        s2_pb_d    = s2_pb_q;
        s2_pc_d    = s2_pc_q;
        s2_pd_d    = s2_pd_q;
        s2_ox_d    = s2_ox_q;
        s2_oy_d    = s2_oy_q;
        if (advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_pa_d = PW'(ma) * PW'(s1_dx_q);
                s2_pb_d = PW'(mb) * PW'(s1_dy_q);
                s2_pc_d = PW'(mc) * PW'(s1_dx_q);
                s2_pd_d = PW'(md) * PW'(s1_dy_q);
                s2_ox_d = s1_ox_q;
                s2_oy_d = s1_oy_q;
            end
        end
    end

    always_comb begin
        sum_u = SW'(s2_pa_q) + SW'(s2_pb_q);
        sum_v = SW'(s2_pc_q) + SW'(s2_pd_q);
        sh_u  = sum_u >>> FRAC;
        sh_v  = sum_v >>> FRAC;
        res_u = RW'(sh_u) + $signed(RW'({1'b0, s2_ox_q}));
        res_v = RW'(sh_v) + $signed(RW'({1'b0, s2_oy_q}));
    end

    always_comb begin
        m_valid_d = m_valid_q;
        tu_d      = tu_q;
        tv_d      = tv_q;
        oob_d     = oob_q;
        if (advance) begin
            m_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                tu_d  = fit(res_u);
                tv_d  = fit(res_v);
                oob_d = out_of_range(res_u) | out_of_range(res_v);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cfg_qx_q   <= '0;
            cfg_qy_q   <= '0;
            cfg_ox_q   <= '0;
            cfg_oy_q   <= '0;
            cfg_m_q    <= M_ID;
            s1_valid_q <= 1'b0;
            s1_dx_q    <= '0;
            s1_dy_q    <= '0;
            s1_m_q     <= M_ID;
            s1_ox_q    <= '0;
            s1_oy_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_pa_q    <= '0;
            s2_pb_q    <= '0;
            s2_pc_q    <= '0;
            s2_pd_q    <= '0;
            s2_ox_q    <= '0;
            s2_oy_q    <= '0;
            m_valid_q  <= 1'b0;
            tu_q       <= '0;
            tv_q       <= '0;
            oob_q      <= 1'b0;
        end else begin
            cfg_qx_q   <= cfg_qx_d;
            cfg_qy_q   <= cfg_qy_d;
            cfg_ox_q   <= cfg_ox_d;
            cfg_oy_q   <= cfg_oy_d;
            cfg_m_q    <= cfg_m_d;
            s1_valid_q <= s1_valid_d;
            s1_dx_q    <= s1_dx_d;
            s1_dy_q    <= s1_dy_d;
            s1_m_q     <= s1_m_d;
            s1_ox_q    <= s1_ox_d;
            s1_oy_q    <= s1_oy_d;
            s2_valid_q <= s2_valid_d;
            s2_pa_q    <= s2_pa_d;
            s2_pb_q    <= s2_pb_d;
            s2_pc_q    <= s2_pc_d;
            s2_pd_q    <= s2_pd_d;
            s2_ox_q    <= s2_ox_d;
            s2_oy_q    <= s2_oy_d;
            m_valid_q  <= m_valid_d;
            tu_q       <= tu_d;
            tv_q       <= tv_d;
            oob_q      <= oob_d;
        end
    end

endmodule

// File: tb/tb_shader_affine_pipe.sv
// Scoreboard bench for shader_affine_pipe: clamping and wrapping
// instances share stimulus; expectations come from an integer model.
module tb_shader_affine_pipe;

    localparam int W = 12;
    localparam int MW = 12;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic            cfg_wen = 1'b0;
    logic [W-1:0]    cfg_qx = '0, cfg_qy = '0, cfg_ox = '0, cfg_oy = '0;
    logic [4*MW-1:0] cfg_m = '0;
    logic            s_valid = 1'b0, m_ready = 1'b1;
    logic [W-1:0]    px = '0, py = '0;
    logic            s_ready, m_valid, oob;
    logic [W-1:0]    tu, tv;
    logic            s_ready_w, m_valid_w, oob_w;
    logic [W-1:0]    tu_w, tv_w;

    always #5 aclk = ~aclk;

    shader_affine_pipe #(.W(W), .MW(MW), .FRAC(8), .SAT(1)) u_sat (
        .aclk(aclk), .aresetn(aresetn), .cfg_wen(cfg_wen),
        .cfg_qx(cfg_qx), .cfg_qy(cfg_qy), .cfg_ox(cfg_ox), .cfg_oy(cfg_oy),
        .cfg_m(cfg_m), .s_valid(s_valid), .s_ready(s_ready),
        .px(px), .py(py), .m_valid(m_valid), .m_ready(m_ready),
        .tu(tu), .tv(tv), .oob(oob)
    );

    shader_affine_pipe #(.W(W), .MW(MW), .FRAC(8), .SAT(0)) u_wrap (
        .aclk(aclk), .aresetn(aresetn), .cfg_wen(cfg_wen),
        .cfg_qx(cfg_qx), .cfg_qy(cfg_qy), .cfg_ox(cfg_ox), .cfg_oy(cfg_oy),
        .cfg_m(cfg_m), .s_valid(s_valid), .s_ready(s_ready_w),
        .px(px), .py(py), .m_valid(m_valid_w), .m_ready(m_ready),
        .tu(tu_w), .tv(tv_w), .oob(oob_w)
    );

    typedef struct {
        int tu_s;
        int tv_s;
        int tu_w;
        int tv_w;
        int oob;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   mqx, mqy, mox, moy, ma, mb, mc, md;
    bit   stall = 1'b0;
    int   htu, htv, hoob;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint floor_div(input longint n);
        if (n >= 0)
            return n / 256;
        return -((-n + 255) / 256);
    endfunction

    function automatic int clamp(input longint r);
        if (r < 0)
            return 0;
        if (r > 4095)
            return 4095;
        return int'(r);
    endfunction

    function automatic exp_t model(input int x, input int y);
        exp_t   e;
        longint dx, dy, u, v;
        dx = longint'(x - mqx);
        dy = longint'(y - mqy);
        u = floor_div(ma * dx + mb * dy) + mox;
        v = floor_div(mc * dx + md * dy) + moy;
        e.tu_s = clamp(u);
        e.tv_s = clamp(v);
        e.tu_w = int'(u & 4095);
        e.tv_w = int'(v & 4095);
        e.oob  = (u < 0 || u > 4095 || v < 0 || v > 4095) ? 1 : 0;
        return e;
    endfunction

    task automatic model_identity();
        mqx = 0; mqy = 0; mox = 0; moy = 0;
        ma = 256; mb = 0; mc = 0; md = 256;
    endtask

    task automatic step(output bit acc, output bit sr);
        @(negedge aclk);
        sr  = s_ready;
        acc = s_valid && s_ready && aresetn;
        @(posedge aclk);
        if (acc)
            sb.push_back(model(int'(px), int'(py)));
        if (cfg_wen && aresetn) begin
            mqx = int'(cfg_qx);
            mqy = int'(cfg_qy);
            mox = int'(cfg_ox);
            moy = int'(cfg_oy);
            ma  = int'($signed(cfg_m[11:0]));
            mb  = int'($signed(cfg_m[23:12]));
            mc  = int'($signed(cfg_m[35:24]));
            md  = int'($signed(cfg_m[47:36]));
        end
        #1;
    endtask

    task automatic set_m(input int a, input int b, input int c, input int d);
        cfg_m = {12'(d), 12'(c), 12'(b), 12'(a)};
    endtask

    task automatic set_cfg(input int qx, input int qy, input int ox,
                           input int oy, input int a, input int b,
                           input int c, input int d);
        bit acc, sr;
        cfg_qx = 12'(qx); cfg_qy = 12'(qy);
        cfg_ox = 12'(ox); cfg_oy = 12'(oy);
        set_m(a, b, c, d);
        cfg_wen = 1'b1;
        s_valid = 1'b0;
        step(acc, sr);
        cfg_wen = 1'b0;
    endtask

    task automatic send1(input int x, input int y);
        bit acc, sr;
        int n;
        px = 12'(x); py = 12'(y);
        s_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            step(acc, sr);
            n++;
        end
        s_valid = 1'b0;
        if (!acc)
            chk("send_timeout", 0, 1);
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            @(negedge aclk);
            cyc++;
        end while (!m_valid && cyc < 10);
    endtask

    task automatic after_out();
        @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        bit acc, sr;
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() > 0; i++)
            step(acc, sr);
        chk("drain_empty", sb.size(), 0);
    endtask

    always @(negedge aclk) begin
        if (!aresetn) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_tu", int'(tu), htu);
                chk("hold_tv", int'(tv), htv);
                chk("hold_oob", int'(oob), hoob);
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("tu_sat", int'(tu), mon_e.tu_s);
                    chk("tv_sat", int'(tv), mon_e.tv_s);
                    chk("oob_sat", int'(oob), mon_e.oob);
                    chk("valid_wrap", int'(m_valid_w), 1);
                    chk("tu_wrap", int'(tu_w), mon_e.tu_w);
                    chk("tv_wrap", int'(tv_w), mon_e.tv_w);
                    chk("oob_wrap", int'(oob_w), mon_e.oob);
                end
            end
            stall = m_valid && !m_ready;
            htu = int'(tu);
            htv = int'(tv);
            hoob = int'(oob);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc, sr;
        int cyc, idx, k;
        model_identity();
        #1;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_tu", int'(tu), 0);
        chk("rst_tv", int'(tv), 0);
        chk("rst_oob", int'(oob), 0);
        chk("rst_s_ready", int'(s_ready), 1);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        set_cfg(100, 50, 0, 0, 256, 0, 0, 256);
        send1(130, 70);
        wait_out(cyc);
        chk("latency", cyc, 3);
        chk("id_tu", int'(tu), 30);
        chk("id_tv", int'(tv), 20);
        chk("id_oob", int'(oob), 0);
        after_out();

        set_cfg(0, 0, 100, 100, 0, -256, 256, 0);
        send1(10, 4);
        wait_out(cyc);
        chk("rot_tu", int'(tu), 96);
        chk("rot_tv", int'(tv), 110);
        after_out();
        set_cfg(0, 0, 0, 0, 0, -256, 256, 0);
        send1(10, 4);
        wait_out(cyc);
        chk("rot0_tu_sat", int'(tu), 0);
        chk("rot0_oob", int'(oob), 1);
        chk("rot0_tu_wrap", int'(tu_w), 4092);
        after_out();

        set_cfg(10, 10, 8, 8, 128, 0, 0, 128);
        send1(17, 3);
        wait_out(cyc);
        chk("scl_tu", int'(tu), 11);
        chk("scl_tv", int'(tv), 4);
        after_out();
        set_cfg(10, 10, 0, 0, 128, 0, 0, 128);
        send1(17, 3);
        wait_out(cyc);
        chk("scl0_tv_wrap", int'(tv_w), 4092);
        chk("scl0_tv_sat", int'(tv), 0);
        chk("scl0_oob", int'(oob), 1);
        after_out();

        // sixteen back-to-back pixels with the sink stalled in cycles 5..9
        set_cfg(3, 1, 20, 30, 256, 64, -32, 200);
        idx = 0;
        k = 0;
        s_valid = 1'b1;
        while (idx < 16 && k < 100) begin
            px = 12'(idx * 37 + 5);
            py = 12'(idx * 11 + 2);
            m_ready = !(k >= 5 && k <= 9);
            step(acc, sr);
            if (k >= 5 && k <= 9)
                chk("bp_s_ready", int'(sr), 0);
            if (acc)
                idx++;
            k++;
        end
        chk("bp_sent", idx, 16);
        drain();

        set_cfg(0, 0, 0, 0, 256, 0, 0, 256);
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            px = 12'(i * 10 + 5);
            py = 12'(i + 1);
            cfg_wen = (i == 4);
            set_m(512, 0, 0, 256);
            step(acc, sr);
            cfg_wen = 1'b0;
            chk("mid_cfg_acc", int'(acc), 1);
        end
        drain();

        for (int i = 0; i < 3; i++) begin
            px = 12'(i + 40);
            py = 12'(i + 50);
            s_valid = 1'b1;
            step(acc, sr);
        end
        s_valid = 1'b0;
        aresetn = 1'b0;
        #1;
        chk("midrst_m_valid", int'(m_valid), 0);
        chk("midrst_tu", int'(tu), 0);
        sb.delete();
        model_identity();
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(acc, sr);
            chk("postrst_idle", int'(m_valid), 0);
        end
        send1(7, 9);
        wait_out(cyc);
        chk("postrst_tu", int'(tu), 7);
        chk("postrst_tv", int'(tv), 9);
        after_out();

        for (int i = 0; i < 400; i++) begin
            s_valid = ($urandom % 4) != 0;
            m_ready = ($urandom % 4) != 0;
            px = 12'($urandom);
            py = 12'($urandom);
            cfg_wen = ($urandom % 16) == 0;
            cfg_qx = 12'($urandom);
            cfg_qy = 12'($urandom);
            cfg_ox = 12'($urandom);
            cfg_oy = 12'($urandom);
            cfg_m = {12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)};
            step(acc, sr);
        end
        cfg_wen = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
